// File: rtl/gf2m_mul.sv
// ---------------------------------------------------------------------------
// gf2m_mul -- digit-serial GF(2^M) multiplier, M = WORD_WIDTH.
//
// Computes dbus = x * y mod f(x), f(x) = x^M + irreducible_poly, using an
// MSB-first interleaved shift/reduce/accumulate. DIGIT multiplier bits are
// consumed per RUN cycle, so a product takes WORD_WIDTH/DIGIT RUN cycles.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   reset            synchronous, active-high reset
//   mod_mul          operation request, held high until done
//   stoy / stox      load sbus into operand y / x (only when idle)
//   square           (GF2M_MUL_SQR_EN only) square x instead of x*y
//   irreducible_poly low terms p(x) of f(x); x^M term is implicit
//   sbus             operand load data
//   dbus             accumulator / result
//   run              high while the multiplication is in progress
//   done             load acknowledge or one-cycle result-ready pulse
//
// Optional feature: define GF2M_MUL_SQR_EN to add the square input.
// ---------------------------------------------------------------------------
module gf2m_mul #(
  parameter int WORD_WIDTH = 256,
  parameter int DIGIT      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mod_mul,
  input  logic                  stoy,
  input  logic                  stox,
`ifdef GF2M_MUL_SQR_EN
  input  logic                  square,
`endif
  input  logic [WORD_WIDTH-1:0] irreducible_poly,
  input  logic [WORD_WIDTH-1:0] sbus,
  output logic [WORD_WIDTH-1:0] dbus,
  output logic                  run,
  output logic                  done
);

  localparam int M          = WORD_WIDTH;
  localparam int NUM_DIGITS = WORD_WIDTH / DIGIT;
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [M-1:0]     x, y, b, acc;
  logic [CNT_W-1:0] cnt;

  logic [M-1:0]     acc_step, b_step, b_start;
  logic             load_ok;

  // Operand loads are only honoured while the block is quiescent.
  assign load_ok = !reset && !mod_mul && (state == IDLE || state == WAIT);

`ifdef GF2M_MUL_SQR_EN
  assign b_start = square ? x : y;
`else
  assign b_start = y;
`endif

  // One RUN cycle worth of MSB-first steps: shift acc, fold the bit that
  // fell off back in via p(x), then add x when the current multiplier bit
  // is set.
  always_comb begin
    // NOTE: blocking assignments here chain the DIGIT steps combinationally;
    // every variable gets a default first so no latch is inferred.
    acc_step = acc;
    b_step   = b;
    for (int i = 0; i < DIGIT; i++) begin
      acc_step = {acc_step[M-2:0], 1'b0}
               ^ (acc_step[M-1] ? irreducible_poly : '0)
               ^ (b_step[M-1]   ? x                : '0);
      b_step   = {b_step[M-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (mod_mul) state_next = RUN;
      RUN:  if (cnt == CNT_W'(1)) state_next = DONE;
      DONE: state_next = WAIT;
      WAIT: if (!mod_mul) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x   <= '0;
      y   <= '0;
      b   <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      if (load_ok && stox) x <= sbus;
      if (load_ok && stoy) y <= sbus;
      unique case (state)
        IDLE: if (mod_mul) begin
          acc <= '0;
          b   <= b_start;
          cnt <= CNT_W'(NUM_DIGITS);
        end
        RUN: begin
          acc <= acc_step;
          b   <= b_step;
          cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign dbus = acc;
  assign run  = (state == RUN);
  assign done = (load_ok && (stox || stoy)) || (!reset && state == DONE);

endmodule

// File: tb/tb_gf2m_mul.sv
// ---------------------------------------------------------------------------
// tb_gf2m_mul -- self-checking bench for gf2m_mul (default parameters).
// Reference: full carry-less product followed by polynomial long division
// by f(x) = x^M + p(x).
// ---------------------------------------------------------------------------
module tb_gf2m_mul;

  localparam int W = 256;
  localparam int D = 8;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         reset, mod_mul, stoy, stox;
  logic [W-1:0] irreducible_poly, sbus;
  logic [W-1:0] dbus;
  logic         run, done;
`ifdef GF2M_MUL_SQR_EN
  logic         square;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gf2m_mul #(.WORD_WIDTH(W), .DIGIT(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .mod_mul          (mod_mul),
    .stoy             (stoy),
    .stox             (stox),
`ifdef GF2M_MUL_SQR_EN
    .square           (square),
`endif
    .irreducible_poly (irreducible_poly),
    .sbus             (sbus),
    .dbus             (dbus),
    .run              (run),
    .done             (done)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] gf_ref(input logic [W-1:0] a, input logic [W-1:0] bb,
                                          input logic [W-1:0] p);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] f;
    prod = '0;
    for (int i = 0; i < W; i++)
      if (bb[i]) prod ^= {{W{1'b0}}, a} << i;
    f = {{(W-1){1'b0}}, 1'b1, p};
    for (int i = 2*W-1; i >= W; i--)
      if (prod[i]) prod ^= f << (i - W);
    return prod[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic load(input logic to_x, input logic to_y, input logic [W-1:0] v);
    @(negedge clk);
    stox = to_x; stoy = to_y; sbus = v;
    #1 check("load_ack", done, 1);
    @(negedge clk);
    stox = 1'b0; stoy = 1'b0;
  endtask

  // Starts an operation, checks the run window and done timing, then keeps
  // mod_mul high for 40 more cycles looking for a restart. Leaves mod_mul high.
  task automatic mul(input string tag, input logic [W-1:0] exp);
    int bad_run, done_cycle, done_cnt, extra;
    bad_run = 0; done_cycle = -1; done_cnt = 0; extra = 0;
    @(negedge clk);
    mod_mul = 1'b1;
    for (int c = 1; c <= N + 1; c++) begin
      @(negedge clk);
      #1;
      if (run !== (c <= N)) bad_run++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
    end
    check({tag, "_run_window"}, bad_run, 0);
    check({tag, "_done_cycle"}, done_cycle, N + 1);
    check(tag, dbus, exp);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (run !== 1'b0) extra++;
      if (done === 1'b1) done_cnt++;
    end
    check({tag, "_no_restart"}, extra, 0);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_hold"}, dbus, exp);
  endtask

  task automatic release_mul();
    @(negedge clk);
    mod_mul = 1'b0;
  endtask

  initial begin
    logic [W-1:0] xv, yv, pv, nv, prev;
    int bad, got_done;

    reset = 1'b1; mod_mul = 1'b0; stoy = 1'b0; stox = 1'b0;
    sbus = '0; irreducible_poly = W'(32'h425);
`ifdef GF2M_MUL_SQR_EN
    square = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_run", run, 0);
    check("rst_done", done, 0);
    check("rst_dbus", dbus, 0);
    reset = 1'b0;

    // Basic product
    load(1, 0, W'(2));
    load(0, 1, W'(3));
    mul("x2_y3", W'(6));
    release_mul();

    // Reduction path
    load(1, 0, W'(1) << (W - 1));
    load(0, 1, W'(2));
    mul("reduce", W'(32'h425));
    release_mul();

    // Zero and identity
    load(1, 0, '0);
    load(0, 1, '1);
    mul("x_zero", '0);
    release_mul();
    load(0, 1, W'(1));
    load(1, 0, W'(32'hDEADBEEF));
    mul("y_one", W'(32'hDEADBEEF));

    // Load during WAIT: acknowledged, dbus untouched
    @(negedge clk);
    mod_mul = 1'b0; stox = 1'b1; sbus = rand_word();
    #1 check("wait_load_ack", done, 1);
    @(negedge clk);
    stox = 1'b0;
    #1 check("wait_load_dbus", dbus, W'(32'hDEADBEEF));

    // Joint load: same value in x and y gives x^2
    xv = rand_word();
    load(1, 1, xv);
    mul("joint_load", gf_ref(xv, xv, irreducible_poly));
    release_mul();

    // Random operands and polynomials
    for (int k = 0; k < 6; k++) begin
      pv = rand_word(); xv = rand_word(); yv = rand_word();
      irreducible_poly = pv;
      load(1, 0, xv);
      load(0, 1, yv);
      mul($sformatf("rand%0d", k), gf_ref(xv, yv, pv));
      release_mul();
    end

    // stox during RUN is ignored and not acknowledged
    xv = rand_word(); yv = rand_word(); nv = ~xv;
    load(1, 0, xv);
    load(0, 1, yv);
    @(negedge clk);
    mod_mul = 1'b1;
    repeat (5) @(negedge clk);
    stox = 1'b1; sbus = nv;
    #1 check("run_load_no_ack", done, 0);
    @(negedge clk);
    stox = 1'b0;
    got_done = 0;
    for (int c = 0; c < N + 5 && !got_done; c++) begin
      @(negedge clk);
      #1 if (done === 1'b1) got_done = 1;
    end
    check("run_load_done_seen", got_done, 1);
    check("run_load_result", dbus, gf_ref(xv, yv, irreducible_poly));
    release_mul();

    // Reset at RUN cycle 10 aborts; loads during reset ignored
    @(negedge clk);
    mod_mul = 1'b1;
    repeat (10) @(negedge clk);
    #1 check("abort_in_run", run, 1);
    reset = 1'b1; mod_mul = 1'b0; stox = 1'b1; sbus = rand_word();
    #1 check("rst_load_no_ack", done, 0);
    @(negedge clk);
    #1;
    check("abort_run", run, 0);
    check("abort_dbus", dbus, 0);
    check("abort_done", done, 0);
    reset = 1'b0; stox = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1 if (done === 1'b1 || run === 1'b1) bad++;
    end
    check("abort_no_done", bad, 0);
    load(0, 1, W'(1));
    mul("x_cleared_by_reset", '0);
    release_mul();

`ifdef GF2M_MUL_SQR_EN
    irreducible_poly = W'(32'h425);
    yv = rand_word();
    load(1, 0, W'(3));
    load(0, 1, yv);
    @(negedge clk);
    square = 1'b1;
    mul("square", W'(5));
    release_mul();
    @(negedge clk);
    square = 1'b0;
    mul("y_retained", gf_ref(W'(3), yv, irreducible_poly));
    release_mul();
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gf2m_mul.md
GF2M_MUL -- requirements
Module: gf2m_mul

Interface
REQ-001 SHALL have parameter: WORD_WIDTH, 256, field degree M and data path width.
REQ-002 SHALL have parameter: DIGIT, 8, multiplier bits consumed per RUN cycle; legal values 1,2,4,8,16,32.
REQ-003 SHALL have ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mod_mul  input  1  operation request; held high by controller until done.
- stoy  input  1  load sbus into operand y.
- stox  input  1  load sbus into operand x.
- irreducible_poly  input  WORD_WIDTH  p(x), where f(x)=x^M+p(x) and the x^M term is implicit.
- sbus  input  WORD_WIDTH  operand load data.
- dbus  output  WORD_WIDTH  accumulator / result.
- run  output  1  multiplication in progress.
- done  output  1  load acknowledge or result-ready pulse.

Function
REQ-004 SHALL compute dbus = x*y mod f(x) over GF(2), where x and y are operands previously loaded.
REQ-005 SHALL implement FSM states IDLE, RUN, DONE, WAIT; run SHALL be 1 exactly in RUN.
REQ-006 In IDLE with mod_mul=1, the block SHALL clear acc, set cnt=WORD_WIDTH/DIGIT, latch b=y, and go to RUN.
REQ-007 Each RUN cycle SHALL apply DIGIT MSB-first steps: acc=acc<<1, XOR p if the pre-shift acc[M-1]=1; then XOR x if b[M-1]=1; then b=b<<1.
REQ-008 RUN SHALL decrement cnt each cycle and go to DONE on the cycle it processes the final digit (cnt==1).
REQ-009 DONE SHALL last exactly one cycle, then go to WAIT.
REQ-010 WAIT SHALL go to IDLE when mod_mul=0; there SHALL be no automatic restart while mod_mul stays high.
REQ-011 Latency: with mod_mul first sampled at edge 0, run SHALL be high for cycles 1..WORD_WIDTH/DIGIT, and done SHALL pulse in cycle WORD_WIDTH/DIGIT+1 (33 for defaults).
REQ-012 dbus SHALL equal acc continuously; the result SHALL be valid from DONE until the next operation start or reset.
REQ-013 stoy/stox SHALL take effect only when mod_mul=0 and the state is IDLE or WAIT; otherwise they SHALL be ignored.
REQ-014 stoy and stox asserted together SHALL load the same sbus value into both x and y.
REQ-015 done SHALL equal (accepted stoy | accepted stox | state==DONE) as a combinational output.
REQ-016 A load during WAIT SHALL NOT alter dbus.
REQ-017 Operand x or y equal to 0 SHALL give 0; y=1 SHALL give x unchanged.

Reset
REQ-018 When reset=1 at a clock edge, the block SHALL set state=IDLE and x, y, b, acc, cnt=0.
REQ-019 Reset SHALL force run=0, dbus=0, and done=0 in the cycle following the edge; while reset=1, loads SHALL be ignored and done SHALL be 0.
REQ-020 Reset during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-021 With macro GF2M_MUL_SQR_EN defined, the block SHALL have an extra 1-bit input square; if square=1 when the operation starts, b SHALL be latched from x, giving dbus = x^2 mod f and leaving y untouched.
REQ-022 Without GF2M_MUL_SQR_EN, the square port SHALL be absent and the block SHALL always compute x*y.

Verification
REQ-023 Load x=2, y=3, pulse mod_mul -> dbus=6; done pulses once, in cycle 33 (DIGIT=8).
REQ-024 p=0x425 (x^10+x^5+x^2+1 low terms), x=1<<255, y=2 -> dbus=0x425 (exercises reduction).
REQ-025 Load x=0, y=0xFFFF..FF -> dbus=0; load y=1, x=0xDEADBEEF -> dbus=0xDEADBEEF.
REQ-026 Assert reset at RUN cycle 10 -> next cycle run=0, dbus=0, done=0, and no done pulse afterward.
REQ-027 Hold mod_mul high for 40 cycles after done -> no second run; stox pulsed during RUN -> x unchanged and done not asserted by it.
REQ-028 With GF2M_MUL_SQR_EN defined, square=1, x=3 -> dbus=5, and y retains its loaded value.
